// File: rtl/joy_db15_tx_if.sv
// Three-wire DB15 joystick link: the reader drives clk/load, the adapter returns serial data.
interface joy_db15_tx_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input joy_data);
    modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// DB15 adapter shift chain: parallel-loads two button words on load low, shifts out on joy_clk rise.
// Pin-to-register latency is SYNC_STAGES+1 clk cycles; load always dominates a coincident shift.
module joy_db15_tx #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          reset,
    joy_db15_tx_if.slave  link,
    input  logic [15:0]   joystick1,
    input  logic [15:0]   joystick2,
    output logic          frame_strobe,
    output logic [5:0]    bit_count,
    output logic          overrun,
    output logic          link_active
);
    localparam logic [16:0] WD_MAX   = 17'(IDLE_TIMEOUT);
    localparam logic [5:0]  BITS_MAX = 6'd32;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] ld_sync;
    logic                   clk_hist;
    logic                   ld_hist;
    logic [31:0]            shreg;
    logic [16:0]            wd_cnt;

    logic clk_rise;
    logic ld_fall;
    logic load_en;
    logic shift_en;

    // Chains reset to 1 so an idle-high load line produces no spurious edge at release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            ld_sync  <= '1;
            clk_hist <= 1'b1;
            ld_hist  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], link.joy_clk};
            ld_sync  <= {ld_sync[SYNC_STAGES-2:0], link.joy_load};
            clk_hist <= clk_sync[SYNC_STAGES-1];
            ld_hist  <= ld_sync[SYNC_STAGES-1];
        end
    end

    assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_hist;
    assign ld_fall  = ~ld_sync[SYNC_STAGES-1] & ld_hist;
    // The load-rise cycle still reloads, so the frame is the word seen as load returns high.
    assign load_en  = ~ld_sync[SYNC_STAGES-1] | ~ld_hist;
    assign shift_en = clk_rise & ~load_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg        <= '1;
            bit_count    <= '0;
            overrun      <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= ld_fall;
            overrun      <= shift_en && (bit_count == BITS_MAX);
            if (load_en) begin
                shreg <= ~{joystick2, joystick1};
            end else if (shift_en) begin
                shreg <= {1'b1, shreg[31:1]};
            end
            if (ld_fall) begin
                bit_count <= '0;
            end else if (shift_en && (bit_count != BITS_MAX)) begin
                bit_count <= bit_count + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= WD_MAX;
        end else if (ld_fall) begin
            wd_cnt <= '0;
        end else if (wd_cnt < WD_MAX) begin
            wd_cnt <= wd_cnt + 17'd1;
        end
    end

    assign link_active   = (wd_cnt < WD_MAX);
    assign link.joy_data = shreg[0];
endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: reader-side stimulus with a frame-level model checked every settled cycle.
module tb_joy_db15_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] joystick1 = '0;
    logic [15:0] joystick2 = '0;
    logic        frame_strobe;
    logic [5:0]  bit_count;
    logic        overrun;
    logic        link_active;

    joy_db15_tx_if link ();

    joy_db15_tx #(.SYNC_STAGES(2), .IDLE_TIMEOUT(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .link         (link),
        .joystick1    (joystick1),
        .joystick2    (joystick2),
        .frame_strobe (frame_strobe),
        .bit_count    (bit_count),
        .overrun      (overrun),
        .link_active  (link_active)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int chg_stamp = 0;

    // Model: the frame word (already active-low) and the number of shifts since its load.
    logic        m_loading = 1'b0;
    logic [31:0] m_word = '1;
    int          m_cnt = 0;
    int          exp_frames = 0;
    int          exp_ovr = 0;
    int          obs_frames = 0;
    int          obs_ovr = 0;

    function automatic logic m_data();
        if (m_loading) return ~joystick1[0];
        if (m_cnt < 32) return m_word[m_cnt];
        return 1'b1;
    endfunction

    function automatic int m_count();
        return m_loading ? 0 : m_cnt;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are compared once every pin change has had time to propagate.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            if (frame_strobe) obs_frames++;
            if (overrun) obs_ovr++;
            if ((cyc - chg_stamp) >= 4) begin
                chk("joy_data", int'(link.joy_data), int'(m_data()));
                chk("bit_count", int'(bit_count), m_count());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift();
        link.joy_clk = 1'b1;
        chg_stamp = cyc;
        if (!m_loading) begin
            if (m_cnt == 32) exp_ovr++;
            else m_cnt++;
        end
        tick(6);
        link.joy_clk = 1'b0;
        chg_stamp = cyc;
        tick(6);
    endtask

    task automatic load_low();
        link.joy_load = 1'b0;
        chg_stamp = cyc;
        m_loading = 1'b1;
        exp_frames++;
    endtask

    task automatic load_high();
        m_word = ~{joystick2, joystick1};
        m_cnt = 0;
        m_loading = 1'b0;
        link.joy_load = 1'b1;
        chg_stamp = cyc;
        tick(6);
    endtask

    task automatic load_pulse();
        load_low();
        tick(6);
        load_high();
    endtask

    // Reader: sample joy_data before each clock rise.
    task automatic read_bits(input int n, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            cap[i] = link.joy_data;
            shift();
        end
    endtask

    logic [31:0] cap;
    int          s;
    int          ovr_before;

    initial begin
        link.joy_clk  = 1'b0;
        link.joy_load = 1'b1;
        tick(3);
        chk("rst_joy_data", int'(link.joy_data), 1);
        chk("rst_bit_count", int'(bit_count), 0);
        chk("rst_frame_strobe", int'(frame_strobe), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_link_active", int'(link_active), 0);
        reset = 1'b0;
        chg_stamp = cyc;
        tick(5);
        chk("link_idle_after_reset", int'(link_active), 0);

        // Watchdog: one load, then silence for the full timeout.
        s = cyc;
        load_pulse();
        tick(s + 95 - cyc);
        chk("link_active_before_timeout", int'(link_active), 1);
        tick(15);
        chk("link_active_after_timeout", int'(link_active), 0);

        // Frame A.
        joystick1 = 16'h0001;
        joystick2 = 16'h8000;
        chg_stamp = cyc;
        tick(6);
        load_pulse();
        chk("model_word_A", int'(m_word), int'(32'h7FFF_FFFE));
        read_bits(32, cap);
        chk("frame_A_bits", int'(cap), int'(32'h7FFF_FFFE));
        chk("frame_A_count", int'(bit_count), 32);
        chk("frame_strobes", obs_frames, exp_frames);
        chk("no_overrun_yet", obs_ovr, 0);

        // Overrun: three more clocks.
        read_bits(3, cap);
        chk("overrun_data", int'(cap[2:0]), 7);
        chk("overrun_pulses", obs_ovr, 3);
        chk("overrun_model", exp_ovr, 3);
        chk("overrun_count_hold", int'(bit_count), 32);

        // Simultaneous load fall and clock rise while bit_count is 32.
        ovr_before = obs_ovr;
        load_low();
        link.joy_clk = 1'b1;
        tick(6);
        chk("simul_bit_count", int'(bit_count), 0);
        chk("simul_no_overrun", obs_ovr, ovr_before);
        chk("simul_frame_strobe", obs_frames, exp_frames);
        link.joy_clk = 1'b0;
        chg_stamp = cyc;
        tick(6);
        load_high();

        // Load dominance: clocks while load is held low.
        joystick1 = 16'h00FF;
        joystick2 = 16'h0000;
        chg_stamp = cyc;
        tick(6);
        load_low();
        tick(6);
        for (int i = 0; i < 5; i++) shift();
        chk("dom_bit_count", int'(bit_count), 0);
        chk("dom_joy_data", int'(link.joy_data), 0);
        load_high();
        read_bits(9, cap);
        chk("dom_bits", int'(cap[8:0]), int'(9'h100));
        chk("dom_count", int'(bit_count), 9);

        // Reset mid-frame.
        joystick1 = 16'hA5C3;
        joystick2 = 16'h3C5A;
        chg_stamp = cyc;
        tick(6);
        load_pulse();
        for (int i = 0; i < 10; i++) shift();
        chk("pre_reset_count", int'(bit_count), 10);
        reset = 1'b1;
        #1;
        chk("async_rst_joy_data", int'(link.joy_data), 1);
        chk("async_rst_bit_count", int'(bit_count), 0);
        m_word = '1;
        m_cnt = 0;
        tick(3);
        reset = 1'b0;
        chg_stamp = cyc;
        tick(6);
        read_bits(2, cap);
        chk("post_reset_idle_data", int'(cap[1:0]), 3);
        load_pulse();
        read_bits(32, cap);
        chk("frame_after_reset", int'(cap), int'(32'hC3A5_5A3C));
        chk("frame_after_reset_count", int'(bit_count), 32);
        chk("final_frame_strobes", obs_frames, exp_frames);
        chk("final_overruns", obs_ovr, exp_ovr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
